// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder controller.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned MAX_W    = 32;

    // Effective B operand: inverted for subtraction (the +1 comes in as carry-in).
    function automatic logic [MAX_W-1:0] eff_b(input logic [MAX_W-1:0] b, input logic sub);
        return sub ? ~b : b;
    endfunction

endpackage

// File: rtl/four_bit_addr.sv
// Shared 4-bit ripple adder datapath with carry in/out.
module four_bit_addr (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum_c,
    output logic       co_c
);

    logic [4:0] total_c;

    // Plain 4-bit add; carry out is bit 4.
    always_comb begin
        total_c = 5'(a) + 5'(b) + 5'(cin);
        sum_c   = total_c[3:0];
        co_c    = total_c[4];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer that adds/subtracts wide operands one nibble per clock through a shared 4-bit adder.
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter  int unsigned NIBBLES = 4,
    localparam int unsigned W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovfl
);

    localparam int unsigned     IDX_W    = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                state;
    logic [W-1:0]          a_reg;
    logic [W-1:0]          b_reg;
    logic [IDX_W-1:0]      idx;
    logic                  carry;

    logic [NIBBLE_W-1:0]   nib_a_c;
    logic [NIBBLE_W-1:0]   nib_b_c;
    logic [NIBBLE_W-1:0]   sum_c;
    logic                  co_c;

    // Select the current nibble of each latched operand.
    always_comb begin
        nib_a_c = '0;
        nib_b_c = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_a_c = a_reg[i*NIBBLE_W +: NIBBLE_W];
                nib_b_c = b_reg[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    four_bit_addr u_add (
        .a     (nib_a_c),
        .b     (nib_b_c),
        .cin   (carry),
        .sum_c (sum_c),
        .co_c  (co_c)
    );

    // Control FSM with operand, carry, index and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovfl   <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= op_a;
                        b_reg  <= W'(eff_b(MAX_W'(op_b), sub));
                        carry  <= sub;
                        idx    <= '0;
                        result <= '0;
                        cout   <= 1'b0;
                        ovfl   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < NIBBLES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            result[i*NIBBLE_W +: NIBBLE_W] <= sum_c;
                        end
                    end
                    carry <= co_c;
                    if (idx == LAST_IDX) begin
                        // Last nibble: publish carry and signed overflow with the done pulse.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= co_c;
                        ovfl  <= (a_reg[W-1] == b_reg[W-1]) && (sum_c[NIBBLE_W-1] != a_reg[W-1]);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: table vectors, corner sequences and random ops against an arithmetic model.
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        start4, sub4, busy4, done4, cout4, ovfl4;
    logic [15:0] a4, b4, res4;
    logic        start2, sub2, busy2, done2, cout2, ovfl2;
    logic [7:0]  a2, b2, res2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .op_a(a4), .op_b(b4),
        .busy(busy4), .done(done4), .result(res4), .cout(cout4), .ovfl(ovfl4)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .op_a(a2), .op_b(b2),
        .busy(busy2), .done(done2), .result(res2), .cout(cout2), .ovfl(ovfl2)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] r;
        logic        c;
        logic        o;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on the full-width operands.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] r, output logic c, output logic o);
        longint ua, ub, sa, sb, st, full, half;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        ua = longint'(a) & (full - 1);
        ub = longint'(b) & (full - 1);
        if (!s) begin
            r = 16'((ua + ub) & (full - 1));
            c = (ua + ub) >= full;
        end else begin
            r = 16'((ua - ub + full) & (full - 1));
            c = ua >= ub;
        end
        sa = (ua >= half) ? ua - full : ua;
        sb = (ub >= half) ? ub - full : ub;
        st = s ? sa - sb : sa + sb;
        o  = (st >= half) || (st < -half);
    endtask

    task automatic set_in(input bit n2, input logic s, input logic [15:0] a, input logic [15:0] b,
                          input logic st);
        if (n2) begin
            start2 = st; sub2 = s; a2 = a[7:0]; b2 = b[7:0];
        end else begin
            start4 = st; sub4 = s; a4 = a; b4 = b;
        end
    endtask

    function automatic logic get_busy(input bit n2); return n2 ? busy2 : busy4; endfunction
    function automatic logic get_done(input bit n2); return n2 ? done2 : done4; endfunction
    function automatic logic get_cout(input bit n2); return n2 ? cout2 : cout4; endfunction
    function automatic logic get_ovfl(input bit n2); return n2 ? ovfl2 : ovfl4; endfunction
    function automatic logic [15:0] get_res(input bit n2); return n2 ? {8'h00, res2} : res4; endfunction

    // Issue one op, scramble inputs after acceptance, wait for done and check timing/width.
    task automatic run_op(input bit n2, input logic [15:0] a, input logic [15:0] b, input logic s,
                          input string tag, output logic [15:0] r, output logic c, output logic o);
        int  n;
        int  edges;
        bit  seen;
        n = n2 ? 2 : 4;
        set_in(n2, s, a, b, 1'b1);
        @(posedge clk); #1;
        set_in(n2, 1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
        check({tag, " busy_at_accept"}, 32'(get_busy(n2)), 32'd1);
        seen  = 1'b0;
        edges = 0;
        while (!seen && edges < n + 4) begin
            @(posedge clk); #1;
            edges++;
            if (get_done(n2)) seen = 1'b1;
            else if (edges < n) check({tag, " busy_run"}, 32'(get_busy(n2)), 32'd1);
        end
        check({tag, " done_latency"}, seen ? 32'(edges) : 32'hFFFF_FFFF, 32'(n));
        check({tag, " busy_at_done"}, 32'(get_busy(n2)), 32'd0);
        r = get_res(n2);
        c = get_cout(n2);
        o = get_ovfl(n2);
        @(posedge clk); #1;
        check({tag, " done_width"}, 32'(get_done(n2)), 32'd0);
        check({tag, " result_hold"}, 32'(get_res(n2)), 32'(r));
    endtask

    task automatic check_result(input string tag, input logic [15:0] r, input logic c, input logic o,
                                input logic [15:0] er, input logic ec, input logic eo);
        check({tag, " result"}, 32'(r), 32'(er));
        check({tag, " cout"}, 32'(c), 32'(ec));
        check({tag, " ovfl"}, 32'(o), 32'(eo));
    endtask

    initial begin
        vec_t        tbl [5];
        logic [15:0] r, er, a0, b0, ra, rb;
        logic        c, o, ec, eo, s0;
        int          dones;

        tbl[0] = '{a: 16'h1234, b: 16'h0FCD, sub: 1'b0, r: 16'h2201, c: 1'b0, o: 1'b0};
        tbl[1] = '{a: 16'hFFFF, b: 16'h0001, sub: 1'b0, r: 16'h0000, c: 1'b1, o: 1'b0};
        tbl[2] = '{a: 16'h7FFF, b: 16'h0001, sub: 1'b0, r: 16'h8000, c: 1'b0, o: 1'b1};
        tbl[3] = '{a: 16'h0005, b: 16'h0007, sub: 1'b1, r: 16'hFFFE, c: 1'b0, o: 1'b0};
        tbl[4] = '{a: 16'h8000, b: 16'h0001, sub: 1'b1, r: 16'h7FFF, c: 1'b1, o: 1'b1};

        rst = 1'b1;
        set_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset busy4", 32'(busy4), 32'd0);
        check("reset done4", 32'(done4), 32'd0);
        check("reset result4", 32'(res4), 32'd0);
        check("reset cout4", 32'(cout4), 32'd0);
        check("reset ovfl4", 32'(ovfl4), 32'd0);
        check("reset result2", 32'(res2), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table on the 16-bit instance.
        for (int i = 0; i < 5; i++) begin
            run_op(1'b0, tbl[i].a, tbl[i].b, tbl[i].sub, $sformatf("vec%0d", i), r, c, o);
            check_result($sformatf("vec%0d", i), r, c, o, tbl[i].r, tbl[i].c, tbl[i].o);
        end

        // start held high with changing operands through RUN and DONE: only the first is taken.
        a0 = 16'h1357; b0 = 16'h2468; s0 = 1'b1;
        model(16, a0, b0, s0, er, ec, eo);
        set_in(1'b0, s0, a0, b0, 1'b1);
        @(posedge clk); #1;
        dones = 0;
        r = 16'h0; c = 1'b0; o = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            set_in(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 1'b1);
            @(posedge clk); #1;
            if (done4) begin
                dones++;
                r = res4; c = cout4; o = ovfl4;
            end
        end
        check("spam done_count", 32'(dones), 32'd1);
        check("spam busy_idle", 32'(busy4), 32'd0);
        check_result("spam first", r, c, o, er, ec, eo);
        ra = 16'h4000; rb = 16'h4000;
        model(16, ra, rb, 1'b0, er, ec, eo);
        run_op(1'b0, ra, rb, 1'b0, "spam next", r, c, o);
        check_result("spam next", r, c, o, er, ec, eo);

        // Reset on the second RUN cycle abandons the op.
        set_in(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", 32'(busy4), 32'd0);
        check("midrst done", 32'(done4), 32'd0);
        check("midrst result", 32'(res4), 32'd0);
        check("midrst cout", 32'(cout4), 32'd0);
        check("midrst ovfl", 32'(ovfl4), 32'd0);
        dones = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (done4) dones++;
        end
        check("midrst no_done", 32'(dones), 32'd0);
        ra = 16'hBEEF; rb = 16'h1111;
        model(16, ra, rb, 1'b1, er, ec, eo);
        run_op(1'b0, ra, rb, 1'b1, "midrst fresh", r, c, o);
        check_result("midrst fresh", r, c, o, er, ec, eo);

        // Random ops on the 16-bit instance.
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); s0 = 1'($urandom);
            model(16, ra, rb, s0, er, ec, eo);
            run_op(1'b0, ra, rb, s0, "rand16", r, c, o);
            check_result($sformatf("rand16 %h%s%h", ra, s0 ? "-" : "+", rb), r, c, o, er, ec, eo);
        end

        // 8-bit instance: byte corners then a random sweep.
        for (int i = 0; i < 16; i++) begin
            ra = (i[0]) ? 16'h0080 : ((i[1]) ? 16'h007F : ((i[2]) ? 16'h00FF : 16'h0000));
            rb = (i[2]) ? 16'h0001 : ((i[3]) ? 16'h0080 : 16'h007F);
            s0 = i[3] ^ i[0];
            model(8, ra, rb, s0, er, ec, eo);
            run_op(1'b1, ra, rb, s0, "corner8", r, c, o);
            check_result($sformatf("corner8 %h%s%h", ra[7:0], s0 ? "-" : "+", rb[7:0]), r, c, o, er, ec, eo);
        end
        for (int i = 0; i < 3000; i++) begin
            ra = {8'h00, 8'($urandom)}; rb = {8'h00, 8'($urandom)}; s0 = 1'($urandom);
            model(8, ra, rb, s0, er, ec, eo);
            run_op(1'b1, ra, rb, s0, "rand8", r, c, o);
            check_result($sformatf("rand8 %h%s%h", ra[7:0], s0 ? "-" : "+", rb[7:0]), r, c, o, er, ec, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
